// File: rtl/t01_ai_placement_stream.sv
// t01_ai_placement_stream
// Enumerates every (rotation, x) placement of one tetromino on a latched
// board, drops each placement one row per clock and streams the landed
// result (merged board, landing row, full-row count) over valid/ready.
module t01_ai_placement_stream #(
    parameter int COLS = 10,
    parameter int ROWS = 20,
    parameter int XW   = $clog2(COLS),
    parameter int YW   = $clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ROWS*COLS-1:0] board_in,
    input  logic [2:0]           piece_type,
    output logic                 cand_valid,
    input  logic                 cand_ready,
    output logic [1:0]           cand_rot,
    output logic [XW-1:0]        cand_x,
    output logic [YW-1:0]        cand_y,
    output logic [2:0]           cand_lines,
    output logic [ROWS*COLS-1:0] cand_board,
    output logic [5:0]           cand_count,
    output logic                 busy,
    output logic                 done
);

    localparam int NB = ROWS * COLS;
    localparam int BW = $clog2(NB);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SPAWN = 3'd1;
    localparam logic [2:0] S_DROP  = 3'd2;
    localparam logic [2:0] S_EMIT  = 3'd3;
    localparam logic [2:0] S_ADV   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // 4x4 piece box, row r occupies bits [15-4r -: 4], MSB of each row is column 0
    function automatic logic [15:0] pattern(input logic [2:0] pt, input logic [1:0] rot);
        logic [15:0] m;
        m = '0;
        case ({pt, rot})
            // I
            5'b000_00: m = 16'b1000_1000_1000_1000;
            5'b000_01: m = 16'b1111_0000_0000_0000;
            // O
            5'b001_00: m = 16'b1100_1100_0000_0000;
            // S
            5'b010_00: m = 16'b0110_1100_0000_0000;
            5'b010_01: m = 16'b1000_1100_0100_0000;
            // Z
            5'b011_00: m = 16'b1100_0110_0000_0000;
            5'b011_01: m = 16'b0100_1100_1000_0000;
            // J
            5'b100_00: m = 16'b1000_1110_0000_0000;
            5'b100_01: m = 16'b1100_1000_1000_0000;
            5'b100_10: m = 16'b1110_0010_0000_0000;
            5'b100_11: m = 16'b0100_0100_1100_0000;
            // L
            5'b101_00: m = 16'b0010_1110_0000_0000;
            5'b101_01: m = 16'b1000_1000_1100_0000;
            5'b101_10: m = 16'b1110_1000_0000_0000;
            5'b101_11: m = 16'b1100_0100_0100_0000;
            // T
            5'b110_00: m = 16'b0100_1110_0000_0000;
            5'b110_01: m = 16'b1000_1100_1000_0000;
            5'b110_10: m = 16'b1110_0100_0000_0000;
            5'b110_11: m = 16'b0100_1100_0100_0000;
            default:   m = '0;
        endcase
        return m;
    endfunction

    // box width = one past the rightmost occupied column
    function automatic int unsigned box_w(input logic [15:0] m);
        int unsigned w;
        w = 0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                if (m[4'(15 - 4 * r - c)]) w = c + 1;
            end
        end
        return w;
    endfunction

    // index of the final rotation for a piece type
    function automatic logic [1:0] last_rot(input logic [2:0] pt);
        logic [1:0] lr;
        case (pt)
            3'd0, 3'd2, 3'd3: lr = 2'd1;
            3'd1:             lr = 2'd0;
            default:          lr = 2'd3;
        endcase
        return lr;
    endfunction

    // every piece cell inside the board and over an empty board bit
    function automatic logic fits(input logic [NB-1:0] b, input logic [15:0] m,
                                  input int unsigned px, input int unsigned py);
        logic ok;
        int unsigned row, col;
        ok = 1'b1;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                row = py + r;
                col = px + c;
                if (m[4'(15 - 4 * r - c)]) begin
                    if (row >= ROWS || col >= COLS) ok = 1'b0;
                    else if (b[BW'(row * COLS + col)]) ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

    // board OR piece placed at (px, py)
    function automatic logic [NB-1:0] merge(input logic [NB-1:0] b, input logic [15:0] m,
                                            input int unsigned px, input int unsigned py);
        logic [NB-1:0] res;
        int unsigned row, col;
        res = b;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                row = py + r;
                col = px + c;
                if (m[4'(15 - 4 * r - c)] && row < ROWS && col < COLS)
                    res[BW'(row * COLS + col)] = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [2:0] count_lines(input logic [NB-1:0] b);
        int unsigned n;
        n = 0;
        for (int unsigned row = 0; row < ROWS; row++) begin
            if (&b[row * COLS +: COLS]) n++;
        end
        return 3'(n);
    endfunction

    logic [2:0]    state;
    logic [NB-1:0] board_q;
    logic [2:0]    ptype_q;
    logic [1:0]    rot;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    logic [15:0]   mask;
    int unsigned   y_test;
    int unsigned   x_max;
    logic          fit_now;
    logic [NB-1:0] merged;
    logic [2:0]    lines_now;

    // placement geometry and drop test for the current (rot, x, y)
    always_comb begin
        mask      = pattern(ptype_q, rot);
        x_max     = COLS - box_w(mask);
        y_test    = (state == S_SPAWN) ? 0 : 32'(y) + 1;
        fit_now   = fits(board_q, mask, 32'(x), y_test);
        merged    = merge(board_q, mask, 32'(x), 32'(y));
        lines_now = count_lines(merged);
    end

    assign busy = (state != S_IDLE);

    // enumeration FSM, candidate registers and handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            board_q    <= '0;
            ptype_q    <= '0;
            rot        <= '0;
            x          <= '0;
            y          <= '0;
            cand_valid <= 1'b0;
            cand_rot   <= '0;
            cand_x     <= '0;
            cand_y     <= '0;
            cand_lines <= '0;
            cand_board <= '0;
            cand_count <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state      <= S_IDLE;
                cand_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            board_q    <= board_in;
                            ptype_q    <= piece_type;
                            cand_count <= '0;
                            rot        <= '0;
                            x          <= '0;
                            state      <= (piece_type == 3'd7) ? S_DONE : S_SPAWN;
                        end
                    end
                    S_SPAWN: begin
                        y     <= '0;
                        state <= fit_now ? S_DROP : S_ADV;
                    end
                    S_DROP: begin
                        if (fit_now) begin
                            y <= y + 1'b1;
                        end else begin
                            cand_valid <= 1'b1;
                            cand_rot   <= rot;
                            cand_x     <= x;
                            cand_y     <= y;
                            cand_board <= merged;
                            cand_lines <= lines_now;
                            state      <= S_EMIT;
                        end
                    end
                    S_EMIT: begin
                        if (cand_ready) begin
                            cand_valid <= 1'b0;
                            cand_count <= cand_count + 6'd1;
                            state      <= S_ADV;
                        end
                    end
                    S_ADV: begin
                        if (32'(x) < x_max) begin
                            x     <= x + 1'b1;
                            state <= S_SPAWN;
                        end else if (rot < last_rot(ptype_q)) begin
                            rot   <= rot + 2'd1;
                            x     <= '0;
                            state <= S_SPAWN;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_t01_ai_placement_stream.sv
// Directed testbench for t01_ai_placement_stream (default 10x20 board).
module tb_t01_ai_placement_stream;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int XW   = 4;
    localparam int YW   = 5;
    localparam int NB   = ROWS * COLS;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [NB-1:0] board_in;
    logic [2:0]    piece_type;
    logic          cand_valid;
    logic          cand_ready;
    logic [1:0]    cand_rot;
    logic [XW-1:0] cand_x;
    logic [YW-1:0] cand_y;
    logic [2:0]    cand_lines;
    logic [NB-1:0] cand_board;
    logic [5:0]    cand_count;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    t01_ai_placement_stream #(.COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .board_in   (board_in),
        .piece_type (piece_type),
        .cand_valid (cand_valid),
        .cand_ready (cand_ready),
        .cand_rot   (cand_rot),
        .cand_x     (cand_x),
        .cand_y     (cand_y),
        .cand_lines (cand_lines),
        .cand_board (cand_board),
        .cand_count (cand_count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pulse start for one rising edge; returns at the following falling edge
    task automatic do_start(input logic [2:0] pt, input logic [NB-1:0] b);
        @(negedge clk);
        start      = 1'b1;
        piece_type = pt;
        board_in   = b;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // wait for a candidate, check it, then let it be accepted (cand_ready=1)
    task automatic expect_cand(input string tag, input int rot, input int x, input int y,
                               input int lines, input int cnt,
                               input bit cb, input logic [NB-1:0] eb);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cand_valid) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, found, 1'b1);
        if (found) begin
            check({tag, "_rot"},   cand_rot,   rot);
            check({tag, "_x"},     cand_x,     x);
            check({tag, "_y"},     cand_y,     y);
            check({tag, "_lines"}, cand_lines, lines);
            check({tag, "_count"}, cand_count, cnt);
            if (cb) check({tag, "_board"}, cand_board, eb);
            @(posedge clk);
        end
    endtask

    // wait for done; any candidate seen first is unexpected
    task automatic expect_done(input string tag, input int cnt);
        bit found;
        bit extra;
        found = 1'b0;
        extra = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (cand_valid) extra = 1'b1;
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_done"},  found, 1'b1);
        check({tag, "_extra"}, extra, 1'b0);
        check({tag, "_count"}, cand_count, cnt);
    endtask

    logic [NB-1:0] eb;
    logic [NB-1:0] b3;
    bit saw;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        board_in   = '0;
        piece_type = 3'd0;
        cand_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", cand_valid, 1'b0);
        check("rst_busy",  busy,       1'b0);
        check("rst_done",  done,       1'b0);
        check("rst_count", cand_count, 6'd0);
        check("rst_board", cand_board, '0);
        check("rst_x",     cand_x,     '0);
        reset = 1'b0;

        // empty board, O: x 0..8 at y=18
        eb = '0;
        eb[180] = 1'b1; eb[181] = 1'b1; eb[190] = 1'b1; eb[191] = 1'b1;
        do_start(3'd1, '0);
        check("o_busy", busy, 1'b1);
        for (int i = 0; i < 9; i++)
            expect_cand("o_empty", 0, i, 18, 0, i, (i == 0), eb);
        expect_done("o_empty", 9);

        // empty board, I, with a start pulse mid-run that must be ignored
        do_start(3'd0, '0);
        @(negedge clk);
        @(negedge clk);
        start      = 1'b1;
        piece_type = 3'd1;
        board_in   = '1;
        @(negedge clk);
        start      = 1'b0;
        board_in   = '0;
        for (int i = 0; i < 10; i++)
            expect_cand("i_r0", 0, i, 16, 0, i, 1'b0, '0);
        for (int i = 0; i < 7; i++)
            expect_cand("i_r1", 1, i, 19, 0, 10 + i, 1'b0, '0);
        expect_done("i_empty", 17);

        // row 19 filled at cols 4..9, I clears one line only at rot1 x=0
        b3 = '0;
        for (int c = 4; c < 10; c++) b3[190 + c] = 1'b1;
        eb = '0;
        for (int c = 0; c < 10; c++) eb[190 + c] = 1'b1;
        do_start(3'd0, b3);
        for (int i = 0; i < 10; i++)
            expect_cand("gap_r0", 0, i, (i < 4) ? 16 : 15, 0, i, 1'b0, '0);
        expect_cand("gap_r1x0", 1, 0, 19, 1, 10, 1'b1, eb);
        for (int i = 1; i < 7; i++)
            expect_cand("gap_r1", 1, i, 18, 0, 10 + i, 1'b0, '0);
        expect_done("gap", 17);

        // bit (0,0) set, O: x=0 skipped
        b3 = '0;
        b3[0] = 1'b1;
        do_start(3'd1, b3);
        for (int i = 1; i < 9; i++)
            expect_cand("o_skip", 0, i, 18, 0, i - 1, 1'b0, '0);
        expect_done("o_skip", 8);

        // backpressure: cand_ready low for 5 cycles
        cand_ready = 1'b0;
        do_start(3'd1, '0);
        saw = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cand_valid) begin
                saw = 1'b1;
                break;
            end
        end
        check("bp_seen", saw, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_valid", cand_valid, 1'b1);
            check("bp_x",     cand_x,     4'd0);
            check("bp_y",     cand_y,     5'd18);
            check("bp_count", cand_count, 6'd0);
        end
        cand_ready = 1'b1;
        @(negedge clk);
        check("bp_acc_valid", cand_valid, 1'b0);
        check("bp_acc_count", cand_count, 6'd1);
        for (int i = 1; i < 9; i++)
            expect_cand("bp_rest", 0, i, 18, 0, i, 1'b0, '0);
        expect_done("bp", 9);

        // piece none: done on the second edge after start, no candidates
        @(negedge clk);
        start      = 1'b1;
        piece_type = 3'd7;
        @(negedge clk);
        start = 1'b0;
        check("none_busy1", busy, 1'b1);
        check("none_done1", done, 1'b0);
        @(negedge clk);
        check("none_done2",  done,       1'b1);
        check("none_valid2", cand_valid, 1'b0);
        check("none_count",  cand_count, 6'd0);
        @(negedge clk);
        check("none_done3", done, 1'b0);
        check("none_busy3", busy, 1'b0);

        // abort during DROP: idle next cycle, no done, no candidate
        do_start(3'd1, '0);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy",  busy,       1'b0);
        check("abort_valid", cand_valid, 1'b0);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || cand_valid || busy) saw = 1'b1;
        end
        check("abort_quiet", saw, 1'b0);

        // asynchronous reset mid-run
        do_start(3'd1, '0);
        expect_cand("ar", 0, 0, 18, 0, 0, 1'b0, '0);
        expect_cand("ar", 0, 1, 18, 0, 1, 1'b0, '0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("ar_busy",  busy,       1'b0);
        check("ar_count", cand_count, 6'd0);
        check("ar_valid", cand_valid, 1'b0);
        check("ar_board", cand_board, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ar_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/t01_ai_placement_stream.md
Name: t01_ai_placement_stream

Overview:
- Parametrised successor to the AI placement enumerator.
- Walks every (rotation, x) placement of one tetromino on a latched board. For each placement it simulates the drop one row per clock.
- Streams one candidate at a time over a valid/ready handshake: merged board, landing row and cleared-line count. It never stores an array of boards.
- Sits between the board register and the AI scoring block, which consumes candidates as they are produced.

Parameters:
COLS, 10, board width in cells (>=4)
ROWS, 20, board height in cells (>=4)
XW, $clog2(COLS), width of x fields
YW, $clog2(ROWS), width of row fields

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin enumeration; sampled only in IDLE
abort  in  1  synchronous cancel; return to IDLE with no done
board_in  in  ROWS*COLS  board; bit row*COLS+col, row 0 = top; latched on accepted start
piece_type  in  3  0=I 1=O 2=S 3=Z 4=J 5=L 6=T, 7=none; latched on accepted start
cand_valid  out  1  candidate fields valid
cand_ready  in  1  consumer accepts candidate
cand_rot  out  2  rotation index
cand_x  out  XW  leftmost column of piece box
cand_y  out  YW  landing row of box top
cand_lines  out  3  full rows in cand_board (0..4)
cand_board  out  ROWS*COLS  latched board OR placed piece; rows are not cleared
cand_count  out  6  candidates emitted so far this run
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset: state=IDLE. All outputs 0. Internal rotation, x, y and latched board cleared.
- Piece cell (y+r, x+c) is occupied when pattern row r has bit c set, with the MSB of each row = c=0.
- Patterns are top/left aligned. Rows are listed top first.
  - I: r0 1000,1000,1000,1000; r1 1111.
  - O: r0 1100,1100.
  - S: r0 0110,1100; r1 1000,1100,0100.
  - Z: r0 1100,0110; r1 0100,1100,1000.
  - J: r0 1000,1110; r1 1100,1000,1000; r2 1110,0010; r3 0100,0100,1100.
  - L: r0 0010,1110; r1 1000,1000,1100; r2 1110,1000; r3 1100,0100,0100.
  - T: r0 0100,1110; r1 1000,1100,1000; r2 1110,0100; r3 0100,1100,0100.
- Rotation counts: I/S/Z = 2, O = 1, J/L/T = 4.
- x range per rotation: 0..COLS-w, where w = box width. Order: rotation ascending, then x ascending.
- "fits(y)": every piece cell has row < ROWS and its board bit is 0.
- States:
  - IDLE: on start, latch board_in and piece_type; clear cand_count, rot and x. If piece_type=7, go to DONE; otherwise go to SPAWN.
  - SPAWN (1 cycle): y=0. If fits(0), go to DROP; otherwise the placement is skipped and the FSM goes to ADVANCE.
  - DROP: one row per cycle. If fits(y+1), y<=y+1 and stay in DROP. Otherwise register cand_* fields and go to EMIT.
  - EMIT: cand_valid=1. All cand_* fields are held stable until cand_ready. On valid&&ready, cand_count increments and the FSM goes to ADVANCE; cand_valid drops the next cycle.
  - ADVANCE (1 cycle): if x < xmax, x++ and go to SPAWN. Else if rot < last, rot++, x=0 and go to SPAWN. Else go to DONE.
  - DONE: done=1 for 1 cycle, then IDLE. cand_count keeps its value until the next start.
- Latency: a candidate landing at y reaches EMIT 1+(y+1) cycles after entering SPAWN.
- cand_lines: combinational count of full rows in the merged board, registered together with cand_board.
- start while busy: ignored.
- abort: has priority over every state. Next state is IDLE, cand_valid=0 and done is not pulsed.
- Async reset mid-run: immediate return to reset values.
- cand_ready while cand_valid=0: ignored.

Test Plan:
- Empty board, piece O, cand_ready=1 -> 9 candidates, x=0..8, rot=0, y=18, lines=0; done pulse; cand_count=9.
- Empty board, piece I -> rot0: 10 candidates, y=16. Then rot1: 7 candidates, y=19. cand_count=17.
- Row 19 full except cols 0..3, piece I -> candidate rot1 x=0 has y=19, lines=1 and row 19 all ones in cand_board; all other candidates have lines=0.
- Board bit (0,0) set, piece O -> x=0 skipped (no emit), 8 candidates x=1..8; cand_count=8.
- cand_ready held low 5 cycles during EMIT -> cand_valid and all fields stable for those cycles; exactly one count increment on acceptance.
- piece_type=7 -> done 2 cycles after start, no candidates. abort during DROP -> IDLE next cycle, no done. start asserted while busy -> no effect on the current run.
